// File: rtl/ysyx_22040759_iram_resp.sv
// ysyx_22040759_iram_resp: instruction-SRAM responder for the IF fetch port.
// A 64-bit word store is filled with NOPs by a self-clearing init FSM after
// reset. After the fill, a loader port writes the program image. Each enabled
// fetch returns a registered 32-bit half-word one cycle later.
// Optional build macro IRAM_WR_BYPASS_EN: a same-edge loader write and fetch
// to the same word return the new data (write-first). The default is read-first.
module ysyx_22040759_iram_resp #(
    parameter int unsigned DEPTH    = 4096,
    parameter logic [63:0] BASE     = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_ram_en,
    input  logic [63:0]              inst_raddr,
    output logic [31:0]              inst,
    output logic                     addr_err,
    output logic                     init_done,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [63:0]              ld_data,
    output logic                     ld_ready
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            init_done_q, init_done_d;
    logic [31:0]     inst_q, inst_d;
    logic            addr_err_q, addr_err_d;

    logic [63:0]     mem [DEPTH];

    logic [63:0]     off;
    logic            fetch_err;
    logic [AW-1:0]   word_idx;
    logic [63:0]     rd_word;
    logic            ld_we;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [63:0]     mem_wdata;

    // The wrapping subtract is safe because any address below BASE is rejected first.
    assign off       = inst_raddr - BASE;
    assign fetch_err = (inst_raddr < BASE) || (off >= SPAN) || (inst_raddr[1:0] != 2'b00);
    assign word_idx  = off[3 +: AW];
    assign ld_we     = ld_en && init_done_q;

    // Fill sequencing: sweep every index once, then park in READY until the next reset.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = (state_q == ST_READY);
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // The single store write port serves the NOP fill first, then the loader once ready.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = {NOP_INST, NOP_INST};
        end else if (ld_we) begin
            mem_we = 1'b1;
        end
    end

    // Fetch response: hold while idle, NOP during fill, flag bad addresses, else select a half.
    always_comb begin
        rd_word = mem[word_idx];
`ifdef IRAM_WR_BYPASS_EN
        if (ld_we && (ld_addr == word_idx)) begin
            rd_word = ld_data;
        end
`endif
        inst_d     = inst_q;
        addr_err_d = addr_err_q;
        if (i_ram_en) begin
            if (state_q != ST_READY) begin
                inst_d     = NOP_INST;
                addr_err_d = 1'b0;
            end else if (fetch_err) begin
                inst_d     = NOP_INST;
                addr_err_d = 1'b1;
            end else begin
                inst_d     = inst_raddr[2] ? rd_word[63:32] : rd_word[31:0];
                addr_err_d = 1'b0;
            end
        end
    end

    // Control and response registers; the store itself is not reset and is refilled instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            inst_q      <= NOP_INST;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            inst_q      <= inst_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Store write. Without the bypass, a same-edge read sees the old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign inst      = inst_q;
    assign addr_err  = addr_err_q;
    assign init_done = init_done_q;
    assign ld_ready  = init_done_q;

endmodule

// File: tb/tb_ysyx_22040759_iram_resp.sv
// Directed bench for ysyx_22040759_iram_resp with DEPTH=16. All expected values are
// hand-computed constants. It follows IRAM_WR_BYPASS_EN for the same-edge case.
module tb_ysyx_22040759_iram_resp;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        i_ram_en;
    logic [63:0] inst_raddr;
    logic [31:0] inst;
    logic        addr_err;
    logic        init_done;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [63:0] ld_data;
    logic        ld_ready;

    int n_compared;
    int n_mismatched;

    ysyx_22040759_iram_resp #(
        .DEPTH    (16),
        .BASE     (64'h0000_0000_8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ram_en   (i_ram_en),
        .inst_raddr (inst_raddr),
        .inst       (inst),
        .addr_err   (addr_err),
        .init_done  (init_done),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [63:0] addr,
                                 input logic le, input logic [3:0] la, input logic [63:0] ld);
        i_ram_en   = en;
        inst_raddr = addr;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ld;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk the 16-cycle fill from release. Fetches return NOP, and init_done rises on edge 17.
    // When doLoad is set, a loader write to word 3 is attempted while ld_ready is low.
    task automatic fillCheck(input string phase, input bit doLoad);
        for (int k = 1; k <= 17; k++) begin
            if (doLoad && k == 10) applyStimulus(1'b1, 64'h8000_0008, 1'b1, 4'd3, 64'hBAD0_BAD0_BAD0_BAD0);
            step();
            if (doLoad && k == 10) applyStimulus(1'b1, 64'h8000_0008, 1'b0, 4'd0, 64'h0);
            if (k <= 16) begin
                checkOutput({phase, "_inst"}, inst, NOP);
                checkOutput({phase, "_err"}, addr_err, 1'b0);
                checkOutput({phase, "_init_low"}, init_done, 1'b0);
            end else begin
                checkOutput({phase, "_init_high"}, init_done, 1'b1);
                checkOutput({phase, "_ld_ready"}, ld_ready, 1'b1);
            end
        end
    endtask

    // Issue one fetch and check the result one edge later.
    task automatic fetchCheck(input string tag, input logic [63:0] addr,
                              input logic [31:0] expInst, input logic expErr);
        applyStimulus(1'b1, addr, 1'b0, 4'd0, 64'h0);
        step();
        checkOutput({tag, "_inst"}, inst, expInst);
        checkOutput({tag, "_err"}, addr_err, expErr);
    endtask

    // Write one word through the loader with the fetch port idle.
    task automatic loadWord(input logic [3:0] la, input logic [63:0] ld);
        applyStimulus(1'b0, 64'h8000_0000, 1'b1, la, ld);
        step();
        applyStimulus(1'b0, 64'h8000_0000, 1'b0, 4'd0, 64'h0);
    endtask

    // Directed sequence covering reset, fill, loads, errors, hold, the same-edge case and resets.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        applyStimulus(1'b1, 64'h8000_0000, 1'b0, 4'd0, 64'h0);
        repeat (2) step();
        checkOutput("rst_inst", inst, NOP);
        checkOutput("rst_err", addr_err, 1'b0);
        checkOutput("rst_init", init_done, 1'b0);
        checkOutput("rst_ld_ready", ld_ready, 1'b0);

        rst_n = 1'b1;
        fillCheck("fill1", 1'b0);

        loadWord(4'd1, 64'h00A0_0093_0050_0113);
        fetchCheck("w1_lo", 64'h8000_0008, 32'h0050_0113, 1'b0);
        fetchCheck("w1_hi", 64'h8000_000C, 32'h00A0_0093, 1'b0);

        loadWord(4'd15, 64'hDEAD_BEEF_CAFE_F00D);
        fetchCheck("w15_lo", 64'h8000_0078, 32'hCAFE_F00D, 1'b0);
        fetchCheck("w15_hi", 64'h8000_007C, 32'hDEAD_BEEF, 1'b0);
        fetchCheck("w2_nop", 64'h8000_0010, NOP, 1'b0);

        fetchCheck("below_base", 64'h0000_0000_7FFF_FFFC, NOP, 1'b1);
        fetchCheck("w15_ok", 64'h8000_007C, 32'hDEAD_BEEF, 1'b0);
        fetchCheck("past_end", 64'h0000_0000_8000_0080, NOP, 1'b1);
        fetchCheck("misalign", 64'h0000_0000_8000_0002, NOP, 1'b1);
        fetchCheck("wrap_top", 64'hFFFF_FFFF_FFFF_FFF8, NOP, 1'b1);
        fetchCheck("recover", 64'h8000_0008, 32'h0050_0113, 1'b0);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 64'h8000_000C + 64'(k * 4), 1'b0, 4'd0, 64'h0);
            step();
            checkOutput("hold_inst", inst, 32'h0050_0113);
            checkOutput("hold_err", addr_err, 1'b0);
        end

        applyStimulus(1'b1, 64'h8000_0008, 1'b1, 4'd1, 64'h1111_1111_2222_2222);
        step();
`ifdef IRAM_WR_BYPASS_EN
        checkOutput("same_edge", inst, 32'h2222_2222);
`else
        checkOutput("same_edge", inst, 32'h0050_0113);
`endif
        fetchCheck("after_write", 64'h8000_0008, 32'h2222_2222, 1'b0);

        rst_n = 1'b0;
        #2;
        checkOutput("async_rst_ready_inst", inst, NOP);
        checkOutput("async_rst_ready_init", init_done, 1'b0);
        checkOutput("async_rst_ready_ldr", ld_ready, 1'b0);
        step();
        applyStimulus(1'b1, 64'h8000_0008, 1'b0, 4'd0, 64'h0);
        rst_n = 1'b1;
        repeat (7) step();
        checkOutput("midfill_init", init_done, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("async_rst_fill_inst", inst, NOP);
        checkOutput("async_rst_fill_err", addr_err, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        fillCheck("fill2", 1'b1);

        fetchCheck("refilled_w1", 64'h8000_0008, NOP, 1'b0);
        fetchCheck("dropped_ld_w3", 64'h8000_0018, NOP, 1'b0);
        fetchCheck("refilled_w15", 64'h8000_007C, NOP, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
